// File: rtl/mp64_multiplier_pkg.sv
// Shared definitions for the MP64 multiplier: operand and product widths,
// the default latency, the control FSM states and a small sign helper.
package mp64_pkg;

  localparam int XLEN            = 64;
  localparam int PLEN            = 2 * XLEN;
  localparam int LATENCY_DEFAULT = 4;
  localparam int LATENCY_MAX     = 8;

  // Number of register boundaries the arithmetic naturally splits into:
  // partial products, two partial sums, final sum, conditional negate.
  localparam int NATURAL_DEPTH   = 4;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [PLEN-1:0] prod_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Absolute value of an operand when it is to be read as two's complement.
  // The most negative value maps to 2^63, which is still exact as unsigned.
  function automatic word_t magnitude(input word_t value, input logic is_signed);
    word_t neg_value;
    neg_value = word_t'(-value);
    return (is_signed && value[XLEN-1]) ? neg_value : value;
  endfunction

endpackage

// File: rtl/mp64_multiplier_if.sv
// Request/response bundle between the execute stage and the multiplier.
// The requester drives the operands and start strobe; the multiplier
// returns the product with a done strobe and a busy flag.
interface mp64_multiplier_if;
  import mp64_pkg::*;

  logic  start;
  logic  is_signed;
  word_t a;
  word_t b;
  prod_t result;
  logic  done;
  logic  busy;

  modport master (
    output start,
    output is_signed,
    output a,
    output b,
    input  result,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  is_signed,
    input  a,
    input  b,
    output result,
    output done,
    output busy
  );

endinterface

// File: rtl/mp64_multiplier_pp32.sv
// 32x32 -> 64 unsigned partial-product unit. Normally registered; the
// register can be removed when the surrounding pipeline is too short to
// give the multiply a stage of its own.
module mp64_mul_pp32 #(
  parameter bit REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] p
);

  if (REG) begin : g_reg
    logic [63:0] p_q;

    // Register the product so the multiply is the whole stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        p_q <= '0;
      end else begin
        p_q <= 64'(x) * 64'(y);
      end
    end

    assign p = p_q;
  end else begin : g_comb
    logic unused_ok;

    assign unused_ok = &{1'b0, clk, rst};
    assign p         = 64'(x) * 64'(y);
  end

endmodule

// File: rtl/mp64_multiplier.sv
// MP64 execute-stage 64x64 -> 128 multiplier, signed or unsigned.
// Operands are captured as magnitudes plus a result-sign flag, multiplied
// as four 32x32 partial products, summed in two adder stages and finally
// negated when the signs differ. The pipeline depth equals LATENCY: short
// latencies merge stages, long ones append delay registers.
module mp64_multiplier
  import mp64_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  mp64_multiplier_if.slave bus
);

  localparam bit REG_PP  = (LATENCY >= 2);
  localparam bit REG_SUM = (LATENCY >= 3);
  localparam bit REG_PS  = (LATENCY >= NATURAL_DEPTH);
  localparam int N_DELAY = (LATENCY > NATURAL_DEPTH) ? (LATENCY - NATURAL_DEPTH) : 0;
  localparam int CW      = 4;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          done_q;
  logic          done_n;
  logic          accept;
  logic          load_result;

  word_t         a_mag;
  word_t         b_mag;
  logic          neg_q;

  logic [63:0]   pp_ll;
  logic [63:0]   pp_lh;
  logic [63:0]   pp_hl;
  logic [63:0]   pp_hh;

  prod_t         ps_lo_c;
  prod_t         ps_hi_c;
  prod_t         ps_lo;
  prod_t         ps_hi;
  prod_t         sum_c;
  prod_t         sum;
  prod_t         signed_c;
  prod_t         final_val;
  prod_t         result_q;

  // Control state, run counter and the registered done strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      done_q <= done_n;
    end
  end

  // Accept a request only when idle; count down and finish when count hits zero.
  always_comb begin
    state_n     = state;
    count_n     = count;
    done_n      = 1'b0;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = ST_RUN;
          count_n = CW'(LATENCY - 1);
        end
      end
      ST_RUN: begin
        if (count == '0) begin
          state_n     = ST_IDLE;
          done_n      = 1'b1;
          load_result = 1'b1;
        end else begin
          count_n = count - 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Capture operand magnitudes and the sign of the product on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_mag <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      a_mag <= magnitude(bus.a, bus.is_signed);
      b_mag <= magnitude(bus.b, bus.is_signed);
      neg_q <= bus.is_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
    end
  end

  mp64_mul_pp32 #(.REG(REG_PP)) u_pp_ll (
    .clk (clk),
    .rst (rst),
    .x   (a_mag[31:0]),
    .y   (b_mag[31:0]),
    .p   (pp_ll)
  );

  mp64_mul_pp32 #(.REG(REG_PP)) u_pp_lh (
    .clk (clk),
    .rst (rst),
    .x   (a_mag[31:0]),
    .y   (b_mag[63:32]),
    .p   (pp_lh)
  );

  mp64_mul_pp32 #(.REG(REG_PP)) u_pp_hl (
    .clk (clk),
    .rst (rst),
    .x   (a_mag[63:32]),
    .y   (b_mag[31:0]),
    .p   (pp_hl)
  );

  mp64_mul_pp32 #(.REG(REG_PP)) u_pp_hh (
    .clk (clk),
    .rst (rst),
    .x   (a_mag[63:32]),
    .y   (b_mag[63:32]),
    .p   (pp_hh)
  );

  assign ps_lo_c = prod_t'(pp_ll) + (prod_t'(pp_lh) << 32);
  assign ps_hi_c = (prod_t'(pp_hl) << 32) + (prod_t'(pp_hh) << 64);

  if (REG_PS) begin : g_ps_reg
    prod_t ps_lo_q;
    prod_t ps_hi_q;

    // Register the two half sums so each stage holds a single 128-bit add.
    always_ff @(posedge clk) begin
      if (rst) begin
        ps_lo_q <= '0;
        ps_hi_q <= '0;
      end else begin
        ps_lo_q <= ps_lo_c;
        ps_hi_q <= ps_hi_c;
      end
    end

    assign ps_lo = ps_lo_q;
    assign ps_hi = ps_hi_q;
  end else begin : g_ps_comb
    assign ps_lo = ps_lo_c;
    assign ps_hi = ps_hi_c;
  end

  assign sum_c = ps_lo + ps_hi;

  if (REG_SUM) begin : g_sum_reg
    prod_t sum_q;

    // Register the unsigned magnitude of the full product.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
      end else begin
        sum_q <= sum_c;
      end
    end

    assign sum = sum_q;
  end else begin : g_sum_comb
    assign sum = sum_c;
  end

  assign signed_c = neg_q ? prod_t'(-sum) : sum;

  if (N_DELAY > 0) begin : g_delay
    prod_t dly [N_DELAY];

    // Pad the pipeline out to the requested latency.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N_DELAY; i++) begin
          dly[i] <= '0;
        end
      end else begin
        dly[0] <= signed_c;
        for (int i = 1; i < N_DELAY; i++) begin
          dly[i] <= dly[i-1];
        end
      end
    end

    assign final_val = dly[N_DELAY-1];
  end else begin : g_no_delay
    assign final_val = signed_c;
  end

  // Result register loads only on completion and holds until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (load_result) begin
      result_q <= final_val;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state == ST_RUN);

endmodule

// File: tb/tb_mp64_multiplier.sv
// Bench for mp64_multiplier: three instances (LATENCY 1, 4 and 8) share a
// clock and reset; each is exercised with directed and random products,
// mid-flight disturbances, back-to-back requests and resets.
module tb_mp64_multiplier;
  import mp64_pkg::*;

  localparam int NDUT = 3;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start_v [NDUT];
  logic         sgn_v   [NDUT];
  logic [63:0]  a_v     [NDUT];
  logic [63:0]  b_v     [NDUT];
  logic [127:0] res_v   [NDUT];
  logic         done_v  [NDUT];
  logic         busy_v  [NDUT];

  int checks = 0;
  int errors = 0;

  vec_t vecs [11];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 4 : 8);

    mp64_multiplier_if bus ();

    assign bus.start     = start_v[g];
    assign bus.is_signed = sgn_v[g];
    assign bus.a         = a_v[g];
    assign bus.b         = b_v[g];
    assign res_v[g]      = bus.result;
    assign done_v[g]     = bus.done;
    assign busy_v[g]     = bus.busy;

    mp64_multiplier #(.LATENCY(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Exact product from extended operands with plain 128-bit arithmetic.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input logic s);
    logic [127:0] ex;
    logic [127:0] ey;
    ex = s ? {{64{x[63]}}, x} : {64'd0, x};
    ey = s ? {{64{y[63]}}, y} : {64'd0, y};
    return ex * ey;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation on DUT d, optionally poking start mid-flight and
  // optionally issuing the next request in the done cycle.
  task automatic apply_stimulus(input int d, input logic [63:0] x, input logic [63:0] y,
                                input logic s, input bit poke, input bit chained_in,
                                input bit chain_out, input logic [63:0] nx,
                                input logic [63:0] ny, input logic ns);
    logic [127:0] exp;
    int           lat;
    int           first;
    string        pfx;
    exp   = ref_mul(x, y, s);
    lat   = lat_of(d);
    first = 0;
    pfx   = $sformatf("L%0d", lat);
    if (!chained_in) begin
      start_v[d] = 1'b1;
      a_v[d]     = x;
      b_v[d]     = y;
      sgn_v[d]   = s;
      @(posedge clk);
      #1;
    end
    check_output({pfx, "_busy_after_start"}, 128'(busy_v[d]), 128'(1));
    start_v[d] = poke;
    a_v[d]     = rnd64();
    b_v[d]     = rnd64();
    sgn_v[d]   = 1'($urandom_range(0, 1));
    for (int j = 1; j <= lat + 4; j++) begin
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      a_v[d]     = rnd64();
      b_v[d]     = rnd64();
      if (done_v[d] && first == 0) begin
        first = j;
        break;
      end
    end
    check_output({pfx, "_done_latency"}, 128'(first), 128'(lat));
    check_output({pfx, "_result"}, res_v[d], exp);
    check_output({pfx, "_busy_in_done"}, 128'(busy_v[d]), 128'(0));
    if (chain_out) begin
      start_v[d] = 1'b1;
      a_v[d]     = nx;
      b_v[d]     = ny;
      sgn_v[d]   = ns;
      @(posedge clk);
      #1;
      check_output({pfx, "_b2b_no_done"}, 128'(done_v[d]), 128'(0));
      check_output({pfx, "_b2b_hold"}, res_v[d], exp);
    end else begin
      @(posedge clk);
      #1;
      check_output({pfx, "_pulse_once"}, 128'(done_v[d]), 128'(0));
      check_output({pfx, "_idle_after"}, 128'(busy_v[d]), 128'(0));
      check_output({pfx, "_hold"}, res_v[d], exp);
    end
  endtask

  // Reset in the middle of an operation: nothing completes afterwards.
  task automatic reset_mid(input int d);
    int    lat;
    int    seen;
    string pfx;
    lat  = lat_of(d);
    seen = 0;
    pfx  = $sformatf("L%0d", lat);
    start_v[d] = 1'b1;
    a_v[d]     = rnd64() | 64'h1;
    b_v[d]     = rnd64() | 64'h1;
    sgn_v[d]   = 1'b0;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    repeat ((lat - 1 < 3) ? lat - 1 : 3) begin
      @(posedge clk);
      #1;
    end
    check_output({pfx, "_busy_before_rst"}, 128'(busy_v[d]), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output({pfx, "_rst_busy"}, 128'(busy_v[d]), 128'(0));
    check_output({pfx, "_rst_done"}, 128'(done_v[d]), 128'(0));
    check_output({pfx, "_rst_result"}, res_v[d], 128'(0));
    repeat (lat + 3) begin
      @(posedge clk);
      #1;
      if (done_v[d]) seen = 1;
    end
    check_output({pfx, "_no_done_after_rst"}, 128'(seen), 128'(0));
    check_output({pfx, "_result_after_rst"}, res_v[d], 128'(0));
  endtask

  // Reset and start in the same cycle: the reset wins.
  task automatic reset_with_start(input int d);
    string pfx;
    pfx = $sformatf("L%0d", lat_of(d));
    start_v[d] = 1'b1;
    a_v[d]     = 64'd9;
    b_v[d]     = 64'd9;
    sgn_v[d]   = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    rst        = 1'b0;
    check_output({pfx, "_rst_start_busy"}, 128'(busy_v[d]), 128'(0));
    repeat (lat_of(d) + 2) @(posedge clk);
    #1;
    check_output({pfx, "_rst_start_result"}, res_v[d], 128'(0));
  endtask

  initial begin
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] n1;
    logic [63:0] n2;
    logic        rs;
    logic        ns;

    vecs[0]  = '{64'd7, 64'd6, 1'b0};
    vecs[1]  = '{64'd0, 64'hDEADBEEF, 1'b0};
    vecs[2]  = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[3]  = '{64'h1_0000_0000, 64'h1_0000_0000, 1'b0};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5]  = '{64'd100, 64'd200, 1'b1};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
    vecs[8]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b1};
    vecs[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
    vecs[10] = '{64'd3, 64'd4, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      start_v[d] = 1'b0;
      sgn_v[d]   = 1'b0;
      a_v[d]     = '0;
      b_v[d]     = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_output($sformatf("L%0d_reset_result", lat_of(d)), res_v[d], 128'(0));
      check_output($sformatf("L%0d_reset_done", lat_of(d)), 128'(done_v[d]), 128'(0));
      check_output($sformatf("L%0d_reset_busy", lat_of(d)), 128'(busy_v[d]), 128'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int d = 0; d < NDUT; d++) begin
      $display("[TB] exercising LATENCY=%0d", lat_of(d));

      for (int i = 0; i < 11; i++) begin
        apply_stimulus(d, vecs[i].a, vecs[i].b, vecs[i].s, (i % 2) == 1, 1'b0, 1'b0,
                       64'd0, 64'd0, 1'b0);
      end

      r1 = rnd64();
      r2 = rnd64();
      rs = 1'($urandom_range(0, 1));
      n1 = rnd64();
      n2 = rnd64();
      ns = 1'($urandom_range(0, 1));
      apply_stimulus(d, r1, r2, rs, 1'b0, 1'b0, 1'b1, n1, n2, ns);
      apply_stimulus(d, n1, n2, ns, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0);

      repeat (6) begin
        r1 = rnd64();
        r2 = ($urandom_range(0, 3) == 0) ? 64'(int'($urandom_range(0, 20)) - 10) : rnd64();
        rs = 1'($urandom_range(0, 1));
        apply_stimulus(d, r1, r2, rs, 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                       64'd0, 64'd0, 1'b0);
      end

      apply_stimulus(d, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      reset_mid(d);
      reset_with_start(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
